// File: rtl/convert_fixed_to_float_v_pkg.sv
// Shared types and constants for the fixed-to-float return path.
// State encoding and IEEE-754 single precision constants.
package convert_fixed_to_float_v_pkg;

    localparam int P = 32;
    localparam int FRAC_DEF = 26;
    localparam logic [7:0] BIAS = 8'd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_PACK = 2'd2
    } state_e;

endpackage

// File: rtl/convert_fixed_to_float_v_fixed_abs_32.sv
// Combinational two's-complement magnitude of a 32-bit word.
// 32'h80000000 yields 32'h80000000, read as unsigned 2^31.
module fixed_abs_32 (
    input  logic [31:0] x_i,
    output logic [31:0] mag_o
);

    // Negate when the sign bit is set, pass through otherwise.
    always_comb begin
        mag_o = x_i;
        if (x_i[31]) begin
            mag_o = 32'd0 - x_i;
        end
    end

endmodule

// File: rtl/convert_fixed_to_float_v.sv
// Iterative fixed-point to IEEE-754 single converter.
// Normalizes one bit per cycle, truncates toward zero.
module convert_fixed_to_float_v
    import convert_fixed_to_float_v_pkg::*;
#(
    parameter int FRAC = FRAC_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [P-1:0] FIXED,
    output logic         BUSY,
    output logic         READY,
    output logic [P-1:0] FLOAT
);

    localparam logic [7:0] EXP_TOP = BIAS + 8'(31 - FRAC);

    state_e       state_q;
    logic [P-1:0] mag_q;
    logic         sign_q;
    logic [4:0]   cnt_q;
    logic         zero_q;
    logic         ready_q;
    logic [P-1:0] float_q;

    logic [P-1:0] mag_d;
    logic [7:0]   exp_d;
    logic         zero_d;

    fixed_abs_32 u_abs (
        .x_i   (FIXED),
        .mag_o (mag_d)
    );

    assign zero_d = (FIXED == '0);
    assign exp_d  = EXP_TOP - {3'b000, cnt_q};

    // Control FSM with normalization shifter, counter and packer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            ready_q <= 1'b0;
            float_q <= '0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        sign_q  <= FIXED[P-1];
                        mag_q   <= mag_d;
                        cnt_q   <= '0;
                        zero_q  <= zero_d;
                        state_q <= zero_d ? ST_PACK : ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (mag_q[P-1]) begin
                        state_q <= ST_PACK;
                    end else begin
                        mag_q <= {mag_q[P-2:0], 1'b0};
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_PACK: begin
                    if (zero_q) begin
                        float_q <= '0;
                    end else begin
                        float_q <= {sign_q, exp_d, mag_q[30:8]};
                    end
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY  = (state_q == ST_NORM) || (state_q == ST_PACK);
    assign READY = ready_q;
    assign FLOAT = float_q;

endmodule
